axis_dest_framer: RTL and testbench

- Sits directly downstream of the AXI-stream fan-in stage and consumes its merged stream (tdata/tlast plus binary channel number on tdest).
- Wraps each input packet in a frame: one header beat carrying a magic word, the channel number and a per-channel sequence number, then the data beats, then an optional trailer beat carrying the data-beat count.
- The framed stream feeds the host-link packetizer, so the host can demultiplex channels and detect dropped packets.

---
 rtl/axis_dest_framer.sv | 135 +++++++++++++
 tb/tb_axis_dest_framer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axis_dest_framer.sv
// axis_dest_framer: wraps each input packet in a header / data / optional trailer frame.
// Trailer beat and word count exist only when AXIS_DEST_FRAMER_TRAILER_EN is defined.
module axis_dest_framer #(
    parameter int          NUM_DEST   = 6,
    parameter int          DATA_WIDTH = 128,
    parameter logic [15:0] HDR_MAGIC  = 16'hA55A,
    parameter logic [15:0] TRL_MAGIC  = 16'h5AA5
) (
    input  logic                  s_axis_clk,
    input  logic                  s_axis_rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [NUM_DEST-1:0]   s_axis_tdest,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [NUM_DEST-1:0]   m_axis_tdest
);
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
    typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif
    localparam int IW = NUM_DEST > 1 ? $clog2(NUM_DEST) : 1;
    state_t                state_q, state_d;
    logic [NUM_DEST-1:0]   cur_dest_q, cur_dest_d;
    logic [31:0]           seq_q [NUM_DEST];
    logic [31:0]           seq_d [NUM_DEST];
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [NUM_DEST-1:0]   tdest_q, tdest_d;
    logic                  m_fire, free, in_rng_s, in_rng_c;
    logic [IW-1:0]         s_idx, c_idx;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
    logic [31:0]           wcnt_q, wcnt_d;
`endif
    assign m_fire   = vld_q & m_axis_tready;
    assign free     = ~vld_q | m_axis_tready;
    assign in_rng_s = 32'(s_axis_tdest) < 32'(NUM_DEST);
    assign in_rng_c = 32'(cur_dest_q) < 32'(NUM_DEST);
    assign s_idx    = s_axis_tdest[IW-1:0];
    assign c_idx    = cur_dest_q[IW-1:0];
    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tdest  = tdest_q;

    always_comb begin
        state_d       = state_q;
        cur_dest_d    = cur_dest_q;
        seq_d         = seq_q;
        vld_d         = vld_q & ~m_axis_tready;
        data_d        = data_q;
        last_d        = last_q;
        tdest_d       = tdest_q;
        s_axis_tready = 1'b0;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
        wcnt_d        = wcnt_q;
`endif
        case (state_q)
            IDLE: if (s_axis_tvalid && free) begin
                cur_dest_d = s_axis_tdest;
                tdest_d    = s_axis_tdest;
                vld_d      = 1'b1;
                last_d     = 1'b0;
                data_d     = DATA_WIDTH'({HDR_MAGIC, 16'(s_axis_tdest),
                                          in_rng_s ? seq_q[s_idx] : 32'hFFFF_FFFF});
                state_d    = HEADER;
            end
            HEADER: if (m_fire) begin
                if (in_rng_c) seq_d[c_idx] = seq_q[c_idx] + 32'd1;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
                wcnt_d = '0;
`endif
                state_d = DATA;
            end
            DATA: begin
                s_axis_tready = free;
                if (s_axis_tvalid && free) begin
                    vld_d  = 1'b1;
                    data_d = s_axis_tdata;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
                    wcnt_d = wcnt_q + 32'(wcnt_q != '1);
                    last_d = 1'b0;
                    if (s_axis_tlast) state_d = TRAILER;
`else
                    last_d = s_axis_tlast;
                    if (s_axis_tlast) state_d = IDLE;
`endif
                end
            end
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
            // a held beat with tlast set can only be the trailer itself
            TRAILER: if (vld_q && last_q) begin
                if (m_axis_tready) state_d = IDLE;
            end else if (free) begin
                vld_d  = 1'b1;
                last_d = 1'b1;
                data_d = DATA_WIDTH'({TRL_MAGIC, 16'(cur_dest_q), wcnt_q});
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            state_q    <= IDLE;
            cur_dest_q <= '0;
            for (int i = 0; i < NUM_DEST; i++) seq_q[i] <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            tdest_q    <= '0;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
            wcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_dest_q <= cur_dest_d;
            seq_q      <= seq_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            last_q     <= last_d;
            tdest_q    <= tdest_d;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
            wcnt_q     <= wcnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_axis_dest_framer.sv
// tb_axis_dest_framer: table-driven packets with a scoreboard of expected framed beats.
module tb_axis_dest_framer;
    localparam int DW = 128;
`ifdef AXIS_DEST_FRAMER_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif
    typedef struct {
        logic [5:0]  dest;
        int          len;
        logic [31:0] seq;
        bit          rnd;
    } vec_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [5:0]    dest;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [5:0]    s_tdest = '0;
    logic          m_tvalid, m_tready = 1'b1, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [5:0]    m_tdest;
    int            total = 0, bad = 0;
    bit            rnd_mode = 1'b0, mon_en = 1'b0;
    beat_t         q[$];
    vec_t          vecs[8];

    axis_dest_framer dut (
        .s_axis_clk(clk), .s_axis_rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .m_axis_tdest(m_tdest)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: beats are checked at the negedge before the edge that transfers them
    logic          stall = 1'b0, p_last;
    logic [DW-1:0] p_data;
    logic [5:0]    p_dest;
    always @(negedge clk) begin
        beat_t e;
        if (!mon_en) stall = 1'b0;
        else begin
            if (stall) begin
                total++;
                if (!m_tvalid || m_tdata !== p_data || m_tlast !== p_last || m_tdest !== p_dest) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                             m_tvalid, m_tdata, m_tlast, m_tdest, p_data, p_last, p_dest);
                end
            end
            stall  = m_tvalid & ~m_tready;
            p_data = m_tdata; p_last = m_tlast; p_dest = m_tdest;
            if (m_tvalid && m_tready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: got d=%h l=%b t=%0d want none", m_tdata, m_tlast, m_tdest);
                end else begin
                    e = q.pop_front();
                    if (m_tdata !== e.data || m_tlast !== e.last || m_tdest !== e.dest) begin
                        bad++;
                        $display("FAIL beat: got d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                                 m_tdata, m_tlast, m_tdest, e.data, e.last, e.dest);
                    end
                end
            end
        end
    end

    task automatic send(input logic [5:0] dest, input int len, input logic [31:0] seq, input int stop);
        beat_t         b;
        logic [DW-1:0] d;
        int            n;
        b.data = DW'({16'hA55A, 16'(dest), seq});
        b.last = 1'b0;
        b.dest = dest;
        q.push_back(b);
        for (int i = 0; i < len; i++) begin
            if (i == stop) return;
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.data = d;
            b.last = !TRL && (i == len - 1);
            q.push_back(b);
            s_tvalid = 1'b1; s_tdata = d; s_tlast = (i == len - 1);
            s_tdest  = (i == 0) ? dest : ~dest;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_tready && n < 200);
            if (!s_tready) begin
                total++; bad++;
                $display("FAIL handshake: got tready=0 after %0d cycles want 1", n);
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (TRL) begin
            b.data = DW'({16'h5AA5, 16'(dest), 32'(len)});
            b.last = 1'b1;
            q.push_back(b);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d beats pending want 0", name, q.size());
        end
    endtask

    task automatic chk_idle(input string name);
        total++;
        if ({m_tvalid, m_tdata, m_tlast, m_tdest, s_tready} !== '0) begin
            bad++;
            $display("FAIL %s: got v=%b d=%h l=%b t=%0d rdy=%b want all 0",
                     name, m_tvalid, m_tdata, m_tlast, m_tdest, s_tready);
        end
    endtask

    initial begin
        vecs[0] = '{6'd2, 4,  32'd0,          1'b0};
        vecs[1] = '{6'd2, 1,  32'd1,          1'b0};
        vecs[2] = '{6'd2, 3,  32'd2,          1'b0};
        vecs[3] = '{6'd2, 2,  32'd3,          1'b0};
        vecs[4] = '{6'd5, 1,  32'd0,          1'b0};
        vecs[5] = '{6'd7, 2,  32'hFFFF_FFFF,  1'b0};
        vecs[6] = '{6'd2, 1,  32'd4,          1'b0};
        vecs[7] = '{6'd0, 16, 32'd0,          1'b1};
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("idle_after_reset");
        for (int i = 0; i < 8; i++) begin
            rnd_mode = vecs[i].rnd;
            send(vecs[i].dest, vecs[i].len, vecs[i].seq, -1);
        end
        drain("table_drain");
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset after data beat 2 of a 4-beat packet abandons the frame
        send(6'd5, 4, 32'd1, 2);
        mon_en = 1'b0;
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("mid_frame_reset");
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        send(6'd5, 1, 32'd0, -1);
        send(6'd2, 2, 32'd0, -1);
        send(6'd5, 3, 32'd1, -1);
        drain("post_reset_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
